// File: rtl/id_inst_queue.sv
// rtl/id_inst_queue.sv - IF/ID instruction buffer with optional empty-queue bypass and head-entry decode slicing
module id_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [XLEN-1:0]            enq_pc,
    input  logic [XLEN-1:0]            enq_inst,
    input  logic                       deq_ready,
    input  logic                       flush,
    output logic                       deq_valid,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_inst,
    output logic [6:0]                 opcode,
    output logic [2:0]                 funct3,
    output logic [4:0]                 rd_index,
    output logic [4:0]                 rs1_index,
    output logic [4:0]                 rs2_index,
    output logic [1:0]                 funct7,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic bypass_hit;
    logic pass_through;
    logic enq_fire;
    logic deq_fire;
    logic mem_wr;
    logic mem_rd;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_inst;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign enq_ready = !full;

    // An empty queue with BYPASS presents the incoming entry as the head.
    assign bypass_hit = BYPASS && empty && enq_valid && !flush;
    assign deq_valid  = !flush && (!empty || bypass_hit);

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign pass_through = bypass_hit && deq_ready;
    assign mem_wr       = enq_fire && !pass_through;
    assign mem_rd       = deq_fire && !pass_through;

    assign head_pc   = empty ? enq_pc   : pc_mem[rd_ptr_q];
    assign head_inst = empty ? enq_inst : inst_mem[rd_ptr_q];

    assign deq_pc   = deq_valid ? head_pc   : '0;
    assign deq_inst = deq_valid ? head_inst : '0;

    assign opcode    = deq_inst[6:0];
    assign funct3    = deq_inst[14:12];
    assign rd_index  = deq_inst[11:7];
    assign rs1_index = deq_inst[19:15];
    assign rs2_index = deq_inst[24:20];
    assign funct7    = {deq_inst[30], deq_inst[25]};

    assign count = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (mem_rd) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({mem_wr, mem_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never visible unless count covers it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            pc_mem[wr_ptr_q]   <= enq_pc;
            inst_mem[wr_ptr_q] <= enq_inst;
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// tb/tb_id_inst_queue.sv - scoreboard bench for id_inst_queue
module tb_id_inst_queue;

    localparam int DEPTH  = 4;
    localparam int XLEN   = 32;
    localparam bit BYPASS = 1'b1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enq_valid = 1'b0;
    logic            enq_ready;
    logic [XLEN-1:0] enq_pc = '0;
    logic [XLEN-1:0] enq_inst = '0;
    logic            deq_ready = 1'b0;
    logic            flush = 1'b0;
    logic            deq_valid;
    logic [XLEN-1:0] deq_pc;
    logic [XLEN-1:0] deq_inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd_index;
    logic [4:0]      rs1_index;
    logic [4:0]      rs2_index;
    logic [1:0]      funct7;
    logic [2:0]      count;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb[$];

    id_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .BYPASS(BYPASS)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_inst(enq_inst),
        .deq_ready(deq_ready), .flush(flush),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst),
        .opcode(opcode), .funct3(funct3), .rd_index(rd_index),
        .rs1_index(rs1_index), .rs2_index(rs2_index), .funct7(funct7),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive after negedge, check combinational outputs, update scoreboard across the edge.
    task automatic step(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic fl, output logic acc);
        logic exp_ready;
        logic exp_valid;
        logic [63:0] e;
        @(negedge clk);
        enq_valid = ev; enq_pc = pc; enq_inst = ins; deq_ready = dr; flush = fl;
        #1;
        exp_ready = (sb.size() < DEPTH);
        exp_valid = !fl && (sb.size() > 0 || (BYPASS && ev));
        chk("count", 64'(count), 64'(sb.size()));
        chk("enq_ready", 64'(enq_ready), 64'(exp_ready));
        chk("deq_valid", 64'(deq_valid), 64'(exp_valid));
        acc = ev && exp_ready && !fl;
        if (acc) sb.push_back({pc, ins});
        if (exp_valid && dr) begin
            e = sb.pop_front();
            chk("deq_pc", 64'(deq_pc), 64'(e[63:32]));
            chk("deq_inst", 64'(deq_inst), 64'(e[31:0]));
        end else if (!exp_valid) begin
            chk("idle_pc", 64'(deq_pc), 64'h0);
            chk("idle_inst", 64'(deq_inst), 64'h0);
            chk("idle_opcode", 64'(opcode), 64'h0);
        end
        @(posedge clk);
        if (fl) sb.delete();
    endtask

    task automatic idle_cycle();
        logic a;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
        chk("drained", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        logic acc;
        logic [31:0] pc;
        logic [31:0] ins;

        // reset state
        #12;
        chk("rst_deq_valid", 64'(deq_valid), 64'h0);
        chk("rst_deq_pc", 64'(deq_pc), 64'h0);
        chk("rst_deq_inst", 64'(deq_inst), 64'h0);
        chk("rst_enq_ready", 64'(enq_ready), 64'h1);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_fields", 64'({funct7, rs2_index, rs1_index, rd_index, funct3, opcode}), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // basic flow: same-cycle passthrough, count stays 0
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0, acc);
        idle_cycle();

        // fill to full; 5th entry held by fetch until room appears
        pc = 32'h0;
        ins = $urandom;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pc, ins, 1'b0, 1'b0, acc);
            if (acc) begin pc += 4; ins = $urandom; end
        end
        chk("full_count", 64'(count), 64'h4);
        chk("full_enq_ready", 64'(enq_ready), 64'h0);
        chk("held_pc", 64'(pc), 64'h10);
        for (int i = 0; i < 20 && pc == 32'h10; i++) begin
            step(1'b1, pc, ins, 1'b1, 1'b0, acc);
            if (acc) pc += 4;
        end
        chk("held_accepted", 64'(pc), 64'h14);
        drain();

        // wrap-around at steady count 2
        pc = 32'h100;
        for (int i = 0; i < 2; i++) begin step(1'b1, pc, $urandom, 1'b0, 1'b0, acc); pc += 4; end
        for (int i = 0; i < 10; i++) begin step(1'b1, pc, $urandom, 1'b1, 1'b0, acc); pc += 4; end
        chk("wrap_count", 64'(count), 64'h2);
        drain();

        // flush with 3 held, flush-cycle entry dropped
        pc = 32'h200;
        for (int i = 0; i < 3; i++) begin step(1'b1, pc, $urandom, 1'b0, 1'b0, acc); pc += 4; end
        step(1'b1, 32'hDEAD, 32'hFFFF_FFFF, 1'b1, 1'b1, acc);
        chk("flush_acc", 64'(acc), 64'h0);
        step(1'b1, 32'h300, $urandom, 1'b1, 1'b0, acc);
        idle_cycle();

        // decode fields from storage (non-bypass head)
        step(1'b1, 32'h400, 32'h40B5_0533, 1'b0, 1'b0, acc);
        @(negedge clk);
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("dec_opcode", 64'(opcode), 64'h33);
        chk("dec_funct3", 64'(funct3), 64'h0);
        chk("dec_rd", 64'(rd_index), 64'd10);
        chk("dec_rs1", 64'(rs1_index), 64'd10);
        chk("dec_rs2", 64'(rs2_index), 64'd11);
        chk("dec_funct7", 64'(funct7), 64'h2);
        drain();

        // async reset mid-stream with count = 3
        pc = 32'h500;
        for (int i = 0; i < 3; i++) begin step(1'b1, pc, $urandom, 1'b0, 1'b0, acc); pc += 4; end
        @(negedge clk);
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("pre_arst_count", 64'(count), 64'h3);
        #1 rst = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_deq_valid", 64'(deq_valid), 64'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h600, $urandom, 1'b0, 1'b0, acc);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
